// File: rtl/bitmap_index_encoder.sv
// bitmap_index_encoder
// Accepts a WIDTH-bit vector over valid/ready and serially emits the index of
// every set bit, lowest index first, flagging the final index of each vector.
// An all-zero vector is accepted and dropped, and a one-cycle zero_pulse marks it.
module bitmap_index_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_pulse
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pending;
    logic             r_zero_pulse;

    logic [WIDTH-1:0] w_low_onehot;
    logic [IDX_W-1:0] w_low_idx;
    logic             w_single;
    logic             w_accept;
    logic             w_beat;

    // Isolate the lowest set bit of pending: a bit survives only if every
    // lower bit is clear.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_low
            if (gi == 0) begin : g_first
                assign w_low_onehot[gi] = r_pending[gi];
            end else begin : g_rest
                assign w_low_onehot[gi] = r_pending[gi] & ~(|r_pending[gi-1:0]);
            end
        end
    endgenerate

    // Encode the isolated one-hot bit into its unsigned position.
    always_comb begin
        w_low_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_low_onehot[i]) begin
                w_low_idx = w_low_idx | IDX_W'(i);
            end
        end
    end

    // Exactly one bit left means the current beat is the vector's last.
    assign w_single = (r_pending != '0) && ((r_pending & (r_pending - 1'b1)) == '0);

    assign in_ready   = (r_state == IDLE) && !reset;
    assign out_valid  = (r_state == EMIT);
    assign out_idx    = out_valid ? w_low_idx : '0;
    assign out_last   = out_valid && w_single;
    assign zero_pulse = r_zero_pulse;

    assign w_accept = in_valid && in_ready;
    assign w_beat   = out_valid && out_ready;

    // Capture vectors in IDLE and retire one set bit per accepted beat in EMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pending    <= '0;
            r_zero_pulse <= 1'b0;
        end else begin
            r_zero_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (in_vec != '0) begin
                            r_pending <= in_vec;
                            r_state   <= EMIT;
                        end else begin
                            r_zero_pulse <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (w_beat) begin
                        r_pending <= r_pending & ~w_low_onehot;
                        if (w_single) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitmap_index_encoder.sv
// Directed testbench for bitmap_index_encoder.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
`timescale 1ns/1ps
module tb_bitmap_index_encoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       zero_pulse;

    int errors;
    int checks;

    bitmap_index_encoder #(.WIDTH(8), .IDX_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .zero_pulse (zero_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bundle: {out_valid, out_idx[2:0], out_last, in_ready, zero_pulse}
    logic [6:0] obs;
    assign obs = {out_valid, out_idx, out_last, in_ready, zero_pulse};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== 7'b0_000_0_0_0) begin
            errors++; $display("FAIL reset_hold got=%b exp=%b", obs, 7'b0_000_0_0_0);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b0_000_0_1_0) begin
            errors++; $display("FAIL reset_release got=%b exp=%b", obs, 7'b0_000_0_1_0);
        end
        $display("reset done");
    endtask

    task automatic test_multi_hot();
        logic [2:0] exp_idx [4];
        exp_idx[0] = 3'd1; exp_idx[1] = 3'd2; exp_idx[2] = 3'd5; exp_idx[3] = 3'd7;
        in_valid = 1'b1; in_vec = 8'b1010_0110; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_vec = 8'h00;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs !== {1'b1, exp_idx[k], (k == 3), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL t1_beat%0d got=%b exp=%b", k, obs, {1'b1, exp_idx[k], (k == 3), 1'b0, 1'b0});
            end
            $display("t1 beat %0d idx=%0d last=%0d", k, out_idx, out_last);
            tick();
        end
        checks++;
        if (obs !== 7'b0_000_0_1_0) begin
            errors++; $display("FAIL t1_idle got=%b exp=%b", obs, 7'b0_000_0_1_0);
        end
    endtask

    task automatic test_zero_vector();
        in_valid = 1'b1; in_vec = 8'h00;
        tick();
        in_valid = 1'b0;
        checks++;
        if (obs !== 7'b0_000_0_1_1) begin
            errors++; $display("FAIL t2_pulse got=%b exp=%b", obs, 7'b0_000_0_1_1);
        end
        tick();
        checks++;
        if (obs !== 7'b0_000_0_1_0) begin
            errors++; $display("FAIL t2_after got=%b exp=%b", obs, 7'b0_000_0_1_0);
        end
        $display("t2 zero vector dropped");
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_vec = 8'b1000_0001; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_vec = 8'h00;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs !== 7'b1_000_0_0_0) begin
                errors++; $display("FAIL t3_stall%0d got=%b exp=%b", k, obs, 7'b1_000_0_0_0);
            end
            if (k < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (obs !== 7'b1_000_0_0_0) begin
            errors++; $display("FAIL t3_beat0 got=%b exp=%b", obs, 7'b1_000_0_0_0);
        end
        tick();
        checks++;
        if (obs !== 7'b1_111_1_0_0) begin
            errors++; $display("FAIL t3_beat1 got=%b exp=%b", obs, 7'b1_111_1_0_0);
        end
        tick();
        checks++;
        if (obs !== 7'b0_000_0_1_0) begin
            errors++; $display("FAIL t3_idle got=%b exp=%b", obs, 7'b0_000_0_1_0);
        end
        $display("t3 stall then beats 0,7");
    endtask

    task automatic test_full_vector();
        in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_vec = 8'h00;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (obs !== {1'b1, 3'(k), (k == 7), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL t4_beat%0d got=%b exp=%b", k, obs, {1'b1, 3'(k), (k == 7), 1'b0, 1'b0});
            end
            tick();
        end
        checks++;
        if (obs !== 7'b0_000_0_1_0) begin
            errors++; $display("FAIL t4_idle got=%b exp=%b", obs, 7'b0_000_0_1_0);
        end
        $display("t4 full vector emitted");
    endtask

    task automatic test_reset_mid_emit();
        in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_vec = 8'h00;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs !== {1'b1, 3'(k), 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL t5_beat%0d got=%b exp=%b", k, obs, {1'b1, 3'(k), 1'b0, 1'b0, 1'b0});
            end
            tick();
        end
        // Index 2 is on the bus now; hold it and reset before it is taken.
        out_ready = 1'b0; reset = 1'b1;
        tick();
        checks++;
        if (obs !== 7'b0_000_0_0_0) begin
            errors++; $display("FAIL t5_in_reset got=%b exp=%b", obs, 7'b0_000_0_0_0);
        end
        reset = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (obs !== 7'b0_000_0_1_0) begin
            errors++; $display("FAIL t5_release got=%b exp=%b", obs, 7'b0_000_0_1_0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (obs !== 7'b0_000_0_1_0) begin
                errors++; $display("FAIL t5_quiet%0d got=%b exp=%b", k, obs, 7'b0_000_0_1_0);
            end
        end
        $display("t5 reset discarded remaining beats");
    endtask

    task automatic test_round_trip();
        logic [7:0] dec;
        out_ready = 1'b1;
        for (int code = 0; code < 8; code++) begin
            dec = 8'h01 << code;
            in_valid = 1'b1; in_vec = dec;
            tick();
            in_valid = 1'b0; in_vec = 8'h00;
            checks++;
            if (obs !== {1'b1, 3'(code), 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL t6_code%0d got=%b exp=%b", code, obs, {1'b1, 3'(code), 1'b1, 1'b0, 1'b0});
            end
            tick();
            checks++;
            if (obs !== 7'b0_000_0_1_0) begin
                errors++; $display("FAIL t6_idle%0d got=%b exp=%b", code, obs, 7'b0_000_0_1_0);
            end
            $display("t6 code %0d -> vec %b -> idx %0d", code, dec, code);
        end
    endtask

    task automatic test_back_to_back();
        // Second vector offered right after the last beat is accepted only on the idle cycle.
        out_ready = 1'b1;
        in_valid = 1'b1; in_vec = 8'b0001_0000;
        tick();
        in_vec = 8'b0000_1000;
        checks++;
        if (obs !== 7'b1_100_1_0_0) begin
            errors++; $display("FAIL btb_first got=%b exp=%b", obs, 7'b1_100_1_0_0);
        end
        tick();
        checks++;
        if (obs !== 7'b0_000_0_1_0) begin
            errors++; $display("FAIL btb_gap got=%b exp=%b", obs, 7'b0_000_0_1_0);
        end
        tick();
        in_valid = 1'b0; in_vec = 8'h00;
        checks++;
        if (obs !== 7'b1_011_1_0_0) begin
            errors++; $display("FAIL btb_second got=%b exp=%b", obs, 7'b1_011_1_0_0);
        end
        tick();
        $display("back-to-back vectors separated by one idle cycle");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_multi_hot();
        test_zero_vector();
        test_stall();
        test_full_vector();
        test_reset_mid_emit();
        test_round_trip();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
